csr_file: RTL and testbench
===========================

CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock; one clock domain only.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port csr_en_EXE, input, 1 bit: a CSR instruction is valid in EXE.
REQ-004 SHALL have port csr_op_EXE, input, 2 bits: 01 RW, 10 RS, 11 RC, 00 no write.
REQ-005 SHALL have port csr_addr_EXE, input, 12 bits: CSR address.
REQ-006 SHALL have port csr_write_tmp, input, `data_size bits: write operand (rs1 or zero-extended immediate).
REQ-007 SHALL have port stall, input, 1 bit: pipeline stall; blocks all architectural updates except counters.
REQ-008 SHALL have port retire, input, 1 bit: one instruction retired this cycle.
REQ-009 SHALL have port irq_ext, input, 1 bit: level-sensitive external interrupt.
REQ-010 SHALL have port mret_EXE, input, 1 bit: MRET valid in EXE.
REQ-011 SHALL have port pc_EXE, input, 32 bits: PC of the instruction in EXE.
REQ-012 SHALL have port csr_rdata, output, 32 bits: old CSR value, combinational.
REQ-013 SHALL have port csr_illegal, output, 1 bit: unimplemented address, or write to a read-only CSR.
REQ-014 SHALL have port trap_taken, output, 1 bit: registered, one-cycle PC redirect.
REQ-015 SHALL have port trap_pc, output, 32 bits: redirect target, valid while trap_taken=1.

Function
REQ-016 SHALL implement these CSRs:
- mstatus 0x300: MIE bit 3, MPIE bit 7, MPP bits 12:11 hardwired to 11.
- mie 0x304: MEIE bit 11.
- mtvec 0x305: bits 1:0 read 0.
- mepc 0x341: bits 1:0 read 0.
- mcause 0x342.
- mip 0x344: MEIP bit 11 = irq_ext; read-only.
- mcycle/mcycleh 0xB00/0xB80 and minstret/minstreth 0xB02/0xB82.
- Read-only aliases 0xC00/0xC80/0xC02/0xC82.
- All other bits read 0.
REQ-017 csr_rdata SHALL present the current value at csr_addr_EXE in the same cycle; unimplemented addresses read 0.
REQ-018 A write SHALL commit on the rising edge when csr_en_EXE=1, csr_op_EXE!=00, stall=0, csr_illegal=0, and state=IDLE:
- RW: new = wdata.
- RS: new = old | wdata.
- RC: new = old & ~wdata.
REQ-019 csr_illegal SHALL be 1 only when csr_en_EXE=1 and either the address is unimplemented, or the address is 0xCxx/0x344 with a nonzero write effect. RS/RC with wdata=0 SHALL be legal.
REQ-020 mcycle (64-bit) SHALL increment every cycle, including during stall. minstret SHALL increment when retire=1. Both wrap from 2^64-1 to 0.
REQ-021 A CSR write to any half of a counter SHALL replace that half and suppress that counter's increment for that cycle.
REQ-022 The FSM SHALL have states IDLE and REDIRECT.
REQ-023 In IDLE with stall=0, on mret_EXE=1:
- Set MIE=MPIE and MPIE=1.
- Go to REDIRECT with trap_pc=mepc.
REQ-024 In IDLE with stall=0, mret_EXE=0, and irq_ext & MIE & MEIE:
- Set mepc=pc_EXE, mcause=0x8000000B, MPIE=MIE, MIE=0.
- Go to REDIRECT with trap_pc={mtvec[31:2],2'b00}.
REQ-025 A trap or MRET SHALL discard any same-cycle CSR write. MRET SHALL win over an interrupt in the same cycle; the interrupt is re-evaluated after REDIRECT.
REQ-026 REDIRECT SHALL last exactly one cycle with trap_taken=1, then return to IDLE. CSR writes and trap entry SHALL be ignored in REDIRECT.

Reset
REQ-027 On rst:
- mstatus=0x00001800; all other CSRs and counters = 0.
- state=IDLE; trap_taken=0; trap_pc=0.
REQ-028 Reset asserted mid-REDIRECT SHALL clear trap_taken immediately (asynchronously).

Structure
REQ-029 Package csr_pkg SHALL hold the CSR address constants, the op encoding enum, the FSM state enum, and the cause constant 0x8000000B. `data_size SHALL come from define.sv.
REQ-030 Sub-module csr_counter64 SHALL be instantiated twice, for mcycle and minstret. Ports: inc, wr_lo, wr_hi, wdata, value.

Verification
REQ-031 Reset, then read 0x300 and 0x305 -> csr_rdata=0x00001800, then 0x00000000.
REQ-032 RW 0x305 with 0x80000103 -> readback 0x80000100. Then RS 0x304 with 0x800 -> 0x800. Then RC 0x304 with 0x800 -> 0.
REQ-033 MIE=1, MEIE=1, mtvec=0x100, pc_EXE=0x2000, irq_ext=1, plus a CSR write in the same cycle:
- Next cycle: trap_taken=1, trap_pc=0x100.
- mepc=0x2000, mcause=0x8000000B, MIE=0, MPIE=1.
- The CSR write is discarded.
REQ-034 mret_EXE=1 together with a pending irq_ext:
- trap_taken=1, trap_pc=mepc, MIE=1.
- Interrupt trap follows after REDIRECT.
REQ-035 Load mcycle=0xFFFFFFFF, then hold stall=1 for 2 cycles -> mcycle=0x00000001, mcycleh=1.
REQ-036 Write 0xC00 -> csr_illegal=1 with no state change. RS 0xC00 with 0 -> csr_illegal=0. Address 0x7C0 -> csr_rdata=0, csr_illegal=1.

Source files
------------

// File: rtl/csr_pkg.sv
// csr_pkg: CSR address map, operation/state encodings, trap cause and the
// read-modify-write helpers shared by the CSR file.
package csr_pkg;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH= 12'hB82;

    // User-level read-only counter aliases
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;

    // Machine external interrupt cause
    localparam logic [31:0] CAUSE_M_EXT_IRQ = 32'h8000000B;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } csr_state_e;

    // New CSR value produced by an operation applied to the old value
    function automatic logic [31:0] csr_apply(input csr_op_e op,
                                              input logic [31:0] old_val,
                                              input logic [31:0] wdata);
        logic [31:0] result;
        case (op)
            CSR_OP_RW: result = wdata;
            CSR_OP_RS: result = old_val | wdata;
            CSR_OP_RC: result = old_val & ~wdata;
            default:   result = old_val;
        endcase
        return result;
    endfunction

    // RW always writes; RS/RC with a zero operand leave every bit untouched
    function automatic logic csr_has_effect(input csr_op_e op,
                                            input logic [31:0] wdata);
        logic effect;
        case (op)
            CSR_OP_RW: effect = 1'b1;
            CSR_OP_RS: effect = (wdata != 32'd0);
            CSR_OP_RC: effect = (wdata != 32'd0);
            default:   effect = 1'b0;
        endcase
        return effect;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit free-running counter with independently writable
// 32-bit halves. A write to either half replaces that half and suppresses
// the increment for that cycle.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   inc      : increment request
//   wr_lo    : replace bits 31:0 with wdata
//   wr_hi    : replace bits 63:32 with wdata
//   wdata    : write data
//   value    : current 64-bit count
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    logic [63:0] r_count;

    // Count register: writes take priority over the increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 64'd0;
        end else if (wr_lo) begin
            r_count <= {r_count[63:32], wdata};
        end else if (wr_hi) begin
            r_count <= {wdata, r_count[31:0]};
        end else if (inc) begin
            r_count <= r_count + 64'd1;
        end else begin
            r_count <= r_count;
        end
    end

    assign value = r_count;

endmodule

// File: rtl/define.sv
// Global build-time definitions shared by the CSR block.
`ifndef CSR_DEFINE_SV
`define CSR_DEFINE_SV
`define DATA_SIZE 32
`endif

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file with external-interrupt trap entry and
// MRET handling.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   csr_en_EXE     : CSR instruction valid in EXE
//   csr_op_EXE     : 01 RW, 10 RS, 11 RC, 00 no write
//   csr_addr_EXE   : CSR address
//   csr_write_tmp  : write operand
//   stall          : blocks architectural updates (counters keep running)
//   retire         : one instruction retired this cycle
//   irq_ext        : level-sensitive external interrupt
//   mret_EXE       : MRET valid in EXE
//   pc_EXE         : PC of the instruction in EXE
//   csr_rdata      : old value at csr_addr_EXE (combinational)
//   csr_illegal    : unimplemented address or write to a read-only CSR
//   trap_taken     : one-cycle registered PC redirect
//   trap_pc        : redirect target while trap_taken=1
`include "define.sv"

module csr_file
    import csr_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csr_en_EXE,
    input  logic [1:0]            csr_op_EXE,
    input  logic [11:0]           csr_addr_EXE,
    input  logic [`DATA_SIZE-1:0] csr_write_tmp,
    input  logic                  stall,
    input  logic                  retire,
    input  logic                  irq_ext,
    input  logic                  mret_EXE,
    input  logic [31:0]           pc_EXE,
    output logic [31:0]           csr_rdata,
    output logic                  csr_illegal,
    output logic                  trap_taken,
    output logic [31:0]           trap_pc
);

    // Architectural state
    logic        r_mie;
    logic        r_mpie;
    logic        r_meie;
    logic [29:0] r_mtvec;
    logic [29:0] r_mepc;
    logic [31:0] r_mcause;

    csr_state_e  r_state;
    csr_state_e  w_state_nxt;
    logic        r_trap_taken;
    logic        w_trap_taken_nxt;
    logic [31:0] r_trap_pc;
    logic [31:0] w_trap_pc_nxt;

    // Decode / datapath
    csr_op_e     w_op;
    logic [31:0] w_old;
    logic [31:0] w_new;
    logic        w_impl;
    logic        w_ro;
    logic        w_effect;
    logic        w_illegal;
    logic        w_idle_go;
    logic        w_take_mret;
    logic        w_take_irq;
    logic        w_wr;
    logic [31:0] w_mstatus;
    logic [31:0] w_mie_reg;
    logic [31:0] w_mip;
    logic [63:0] w_mcycle;
    logic [63:0] w_minstret;
    logic        w_unused_pc_bits;

    assign w_op      = csr_op_e'(csr_op_EXE);
    assign w_mstatus = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie, 3'd0};
    assign w_mie_reg = {20'd0, r_meie, 11'd0};
    assign w_mip     = {20'd0, irq_ext, 11'd0};

    // mepc/mtvec are word aligned, so the low PC bits are never stored
    assign w_unused_pc_bits = ^pc_EXE[1:0];

    // Read mux plus implemented/read-only classification of the address
    always_comb begin
        w_old  = 32'd0;
        w_impl = 1'b1;
        w_ro   = 1'b0;
        case (csr_addr_EXE)
            CSR_MSTATUS:   w_old = w_mstatus;
            CSR_MIE:       w_old = w_mie_reg;
            CSR_MTVEC:     w_old = {r_mtvec, 2'b00};
            CSR_MEPC:      w_old = {r_mepc, 2'b00};
            CSR_MCAUSE:    w_old = r_mcause;
            CSR_MIP:       begin w_old = w_mip;              w_ro = 1'b1; end
            CSR_MCYCLE:    w_old = w_mcycle[31:0];
            CSR_MCYCLEH:   w_old = w_mcycle[63:32];
            CSR_MINSTRET:  w_old = w_minstret[31:0];
            CSR_MINSTRETH: w_old = w_minstret[63:32];
            CSR_CYCLE:     begin w_old = w_mcycle[31:0];     w_ro = 1'b1; end
            CSR_CYCLEH:    begin w_old = w_mcycle[63:32];    w_ro = 1'b1; end
            CSR_INSTRET:   begin w_old = w_minstret[31:0];   w_ro = 1'b1; end
            CSR_INSTRETH:  begin w_old = w_minstret[63:32];  w_ro = 1'b1; end
            default:       begin w_old = 32'd0;              w_impl = 1'b0; end
        endcase
    end

    assign w_new     = csr_apply(w_op, w_old, csr_write_tmp);
    assign w_effect  = csr_has_effect(w_op, csr_write_tmp);
    assign w_illegal = csr_en_EXE & (~w_impl | (w_ro & w_effect));

    // MRET outranks the interrupt; both outrank a same-cycle CSR write
    assign w_idle_go   = (r_state == ST_IDLE) & ~stall;
    assign w_take_mret = w_idle_go & mret_EXE;
    assign w_take_irq  = w_idle_go & ~mret_EXE & irq_ext & r_mie & r_meie;
    assign w_wr        = csr_en_EXE & (w_op != CSR_OP_NONE) & w_idle_go
                       & ~w_illegal & ~w_take_mret & ~w_take_irq;

    // Machine status / trap registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mie    <= 1'b0;
            r_mpie   <= 1'b0;
            r_meie   <= 1'b0;
            r_mtvec  <= 30'd0;
            r_mepc   <= 30'd0;
            r_mcause <= 32'd0;
        end else if (w_take_mret) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
        end else if (w_take_irq) begin
            r_mepc   <= pc_EXE[31:2];
            r_mcause <= CAUSE_M_EXT_IRQ;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
        end else if (w_wr) begin
            case (csr_addr_EXE)
                CSR_MSTATUS: begin
                    r_mie  <= w_new[3];
                    r_mpie <= w_new[7];
                end
                CSR_MIE:     r_meie   <= w_new[11];
                CSR_MTVEC:   r_mtvec  <= w_new[31:2];
                CSR_MEPC:    r_mepc   <= w_new[31:2];
                CSR_MCAUSE:  r_mcause <= w_new;
                default:     r_mcause <= r_mcause;
            endcase
        end else begin
            r_mcause <= r_mcause;
        end
    end

    // Cycle counter runs unconditionally, including while stalled
    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (w_wr & (csr_addr_EXE == CSR_MCYCLE)),
        .wr_hi (w_wr & (csr_addr_EXE == CSR_MCYCLEH)),
        .wdata (w_new),
        .value (w_mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire),
        .wr_lo (w_wr & (csr_addr_EXE == CSR_MINSTRET)),
        .wr_hi (w_wr & (csr_addr_EXE == CSR_MINSTRETH)),
        .wdata (w_new),
        .value (w_minstret)
    );

    // FSM state and redirect output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_trap_taken <= 1'b0;
            r_trap_pc    <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_trap_taken <= w_trap_taken_nxt;
            r_trap_pc    <= w_trap_pc_nxt;
        end
    end

    // FSM next state and next redirect outputs
    always_comb begin
        w_state_nxt      = r_state;
        w_trap_taken_nxt = 1'b0;
        w_trap_pc_nxt    = r_trap_pc;
        case (r_state)
            ST_IDLE: begin
                if (w_take_mret) begin
                    w_state_nxt      = ST_REDIRECT;
                    w_trap_taken_nxt = 1'b1;
                    w_trap_pc_nxt    = {r_mepc, 2'b00};
                end else if (w_take_irq) begin
                    w_state_nxt      = ST_REDIRECT;
                    w_trap_taken_nxt = 1'b1;
                    w_trap_pc_nxt    = {r_mtvec, 2'b00};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REDIRECT: w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    assign csr_rdata   = w_old;
    assign csr_illegal = w_illegal;
    assign trap_taken  = r_trap_taken;
    assign trap_pc     = r_trap_pc;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: table-driven CSR accesses followed by
// hand-written trap, MRET, reset and counter sequences, all compared through
// an expected-value queue.
module tb_csr_file;

    logic        clk;
    logic        rst;
    logic        csr_en_EXE;
    logic [1:0]  csr_op_EXE;
    logic [11:0] csr_addr_EXE;
    logic [31:0] csr_write_tmp;
    logic        stall;
    logic        retire;
    logic        irq_ext;
    logic        mret_EXE;
    logic [31:0] pc_EXE;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_taken;
    logic [31:0] trap_pc;

    csr_file dut (
        .clk          (clk),
        .rst          (rst),
        .csr_en_EXE   (csr_en_EXE),
        .csr_op_EXE   (csr_op_EXE),
        .csr_addr_EXE (csr_addr_EXE),
        .csr_write_tmp(csr_write_tmp),
        .stall        (stall),
        .retire       (retire),
        .irq_ext      (irq_ext),
        .mret_EXE     (mret_EXE),
        .pc_EXE       (pc_EXE),
        .csr_rdata    (csr_rdata),
        .csr_illegal  (csr_illegal),
        .trap_taken   (trap_taken),
        .trap_pc      (trap_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    typedef struct {
        string       name;
        logic        en;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_ill;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vt[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    task automatic push_exp(input string name, input logic [31:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] act);
        sb_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got=%h", act);
        end else begin
            e = sb_q.pop_front();
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s got=%h want=%h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        csr_en_EXE    = 1'b0;
        csr_op_EXE    = OP_NONE;
        csr_addr_EXE  = 12'h000;
        csr_write_tmp = 32'd0;
        mret_EXE      = 1'b0;
    endtask

    // Combinational read of one address, checked within the current cycle
    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
        csr_addr_EXE = a;
        push_exp(name, exp);
        #1;
        pop_cmp(csr_rdata);
    endtask

    // One CSR access that commits on the next rising edge
    task automatic csr_wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        csr_en_EXE    = 1'b1;
        csr_op_EXE    = op;
        csr_addr_EXE  = a;
        csr_write_tmp = d;
        step();
        clr();
    endtask

    task automatic add_vec(input string n, input logic en, input logic [1:0] op,
                           input logic [11:0] a, input logic [31:0] d,
                           input logic [31:0] er, input logic ei);
        vec_t v;
        v.name = n; v.en = en; v.op = op; v.addr = a; v.wdata = d;
        v.exp_rdata = er; v.exp_ill = ei;
        vt.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; retire = 1'b0; irq_ext = 1'b0; pc_EXE = 32'd0;
        clr();

        add_vec("rd_mstatus_rst", 1'b0, OP_NONE, 12'h300, 32'h0,        32'h00001800, 1'b0);
        add_vec("rd_mtvec_rst",   1'b0, OP_NONE, 12'h305, 32'h0,        32'h00000000, 1'b0);
        add_vec("rw_mtvec",       1'b1, OP_RW,   12'h305, 32'h80000103, 32'h00000000, 1'b0);
        add_vec("rd_mtvec",       1'b1, OP_NONE, 12'h305, 32'h0,        32'h80000100, 1'b0);
        add_vec("rs_mie",         1'b1, OP_RS,   12'h304, 32'h800,      32'h00000000, 1'b0);
        add_vec("rd_mie_set",     1'b1, OP_NONE, 12'h304, 32'h0,        32'h00000800, 1'b0);
        add_vec("rc_mie",         1'b1, OP_RC,   12'h304, 32'h800,      32'h00000800, 1'b0);
        add_vec("rd_mie_clr",     1'b1, OP_NONE, 12'h304, 32'h0,        32'h00000000, 1'b0);
        add_vec("rw_mepc",        1'b1, OP_RW,   12'h341, 32'h00002003, 32'h00000000, 1'b0);
        add_vec("rd_mepc",        1'b1, OP_NONE, 12'h341, 32'h0,        32'h00002000, 1'b0);
        add_vec("rd_unimpl",      1'b1, OP_NONE, 12'h7C0, 32'h0,        32'h00000000, 1'b1);
        add_vec("rw_mip_zero",    1'b1, OP_RW,   12'h344, 32'h0,        32'h00000000, 1'b1);
        add_vec("rs_mip_zero",    1'b1, OP_RS,   12'h344, 32'h0,        32'h00000000, 1'b0);
        add_vec("rs_mstatus",     1'b1, OP_RS,   12'h300, 32'h88,       32'h00001800, 1'b0);
        add_vec("rd_mstatus_set", 1'b1, OP_NONE, 12'h300, 32'h0,        32'h00001888, 1'b0);
        add_vec("rc_mstatus",     1'b1, OP_RC,   12'h300, 32'h88,       32'h00001888, 1'b0);
        add_vec("rd_mstatus_clr", 1'b1, OP_NONE, 12'h300, 32'h0,        32'h00001800, 1'b0);
        add_vec("rw_mstatus_ff",  1'b1, OP_RW,   12'h300, 32'hFFFFFFFF, 32'h00001800, 1'b0);
        add_vec("rd_mstatus_ff",  1'b1, OP_NONE, 12'h300, 32'h0,        32'h00001888, 1'b0);
        add_vec("rw_mstatus_0",   1'b1, OP_RW,   12'h300, 32'h0,        32'h00001888, 1'b0);
        add_vec("rd_mstatus_0",   1'b0, OP_NONE, 12'h300, 32'h0,        32'h00001800, 1'b0);

        // Reset state of the registered outputs
        #12;
        push_exp("rst_trap_taken", 32'd0);
        pop_cmp({31'd0, trap_taken});
        push_exp("rst_trap_pc", 32'd0);
        pop_cmp(trap_pc);
        step();
        rst = 1'b0;

        // Table-driven CSR accesses
        foreach (vt[i]) begin
            csr_en_EXE    = vt[i].en;
            csr_op_EXE    = vt[i].op;
            csr_addr_EXE  = vt[i].addr;
            csr_write_tmp = vt[i].wdata;
            push_exp({vt[i].name, "_rdata"}, vt[i].exp_rdata);
            push_exp({vt[i].name, "_illegal"}, {31'd0, vt[i].exp_ill});
            #1;
            pop_cmp(csr_rdata);
            pop_cmp({31'd0, csr_illegal});
            step();
        end
        clr();

        // Interrupt entry with a same-cycle CSR write that must be dropped
        csr_wr(OP_RW, 12'h305, 32'h100);
        csr_wr(OP_RS, 12'h304, 32'h800);
        csr_wr(OP_RS, 12'h300, 32'h8);
        pc_EXE = 32'h2000;
        irq_ext = 1'b1;
        csr_en_EXE = 1'b1; csr_op_EXE = OP_RW; csr_addr_EXE = 12'h305; csr_write_tmp = 32'h200;
        push_exp("irq_trap_taken", 32'd1);
        push_exp("irq_trap_pc", 32'h100);
        step();
        clr();
        irq_ext = 1'b0;
        pop_cmp({31'd0, trap_taken});
        pop_cmp(trap_pc);
        rd(12'h341, 32'h2000,     "irq_mepc");
        rd(12'h342, 32'h8000000B, "irq_mcause");
        rd(12'h300, 32'h1880,     "irq_mstatus");
        rd(12'h305, 32'h100,      "irq_write_dropped");
        step();
        push_exp("irq_redirect_end", 32'd0);
        pop_cmp({31'd0, trap_taken});

        // MRET beats a pending interrupt; the interrupt follows after REDIRECT
        irq_ext = 1'b1;
        mret_EXE = 1'b1;
        pc_EXE = 32'h3000;
        push_exp("mret_trap_taken", 32'd1);
        push_exp("mret_trap_pc", 32'h2000);
        step();
        mret_EXE = 1'b0;
        pop_cmp({31'd0, trap_taken});
        pop_cmp(trap_pc);
        rd(12'h300, 32'h1888, "mret_mstatus");
        step();
        push_exp("mret_redirect_end", 32'd0);
        pop_cmp({31'd0, trap_taken});
        push_exp("irq2_trap_taken", 32'd1);
        push_exp("irq2_trap_pc", 32'h100);
        step();
        irq_ext = 1'b0;
        pop_cmp({31'd0, trap_taken});
        pop_cmp(trap_pc);
        rd(12'h341, 32'h3000, "irq2_mepc");

        // Asynchronous reset in the middle of REDIRECT
        #1;
        rst = 1'b1;
        push_exp("async_rst_trap_taken", 32'd0);
        push_exp("async_rst_trap_pc", 32'd0);
        #1;
        pop_cmp({31'd0, trap_taken});
        pop_cmp(trap_pc);
        rd(12'h300, 32'h1800, "async_rst_mstatus");
        step();
        rst = 1'b0;

        // Stall blocks a CSR write
        csr_en_EXE = 1'b1; csr_op_EXE = OP_RW; csr_addr_EXE = 12'h305; csr_write_tmp = 32'h44;
        stall = 1'b1;
        step();
        clr();
        stall = 1'b0;
        rd(12'h305, 32'h0, "stall_blocks_write");

        // mcycle low-half wrap while stalled
        csr_wr(OP_RW, 12'hB00, 32'hFFFFFFFF);
        stall = 1'b1;
        step();
        step();
        stall = 1'b0;
        rd(12'hB00, 32'h1, "mcycle_wrap_lo");
        rd(12'hB80, 32'h1, "mcycle_wrap_hi");
        rd(12'hC00, 32'h1, "cycle_alias_lo");
        rd(12'hC80, 32'h1, "cycle_alias_hi");

        // minstret: writes suppress the retire increment
        retire = 1'b1;
        csr_wr(OP_RW, 12'hB02, 32'h5);
        rd(12'hB02, 32'h5, "minstret_write_wins");
        step();
        retire = 1'b0;
        step();
        rd(12'hC02, 32'h6, "instret_alias");
        retire = 1'b1;
        csr_wr(OP_RW, 12'hB82, 32'h7);
        retire = 1'b0;
        rd(12'hC82, 32'h7, "instreth_alias");
        rd(12'hB02, 32'h6, "minstret_hi_write_suppress");

        // Read-only alias writes
        csr_wr(OP_RW, 12'hB00, 32'h100);
        csr_en_EXE = 1'b1; csr_op_EXE = OP_RW; csr_addr_EXE = 12'hC00; csr_write_tmp = 32'h5;
        push_exp("ro_write_rdata", 32'h100);
        push_exp("ro_write_illegal", 32'd1);
        #1;
        pop_cmp(csr_rdata);
        pop_cmp({31'd0, csr_illegal});
        step();
        csr_op_EXE = OP_RS; csr_write_tmp = 32'h0;
        push_exp("ro_rs0_rdata", 32'h101);
        push_exp("ro_rs0_illegal", 32'd0);
        #1;
        pop_cmp(csr_rdata);
        pop_cmp({31'd0, csr_illegal});
        step();
        clr();
        rd(12'hC00, 32'h102, "ro_no_state_change");
        rd(12'hB80, 32'h1,   "ro_hi_unchanged");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
